// File: rtl/bist_ora_misr.sv
// Output response analyser for the full-adder BIST loop: compacts {carry, sum}
// responses into a Galois MISR over a fixed window and issues a pass/fail verdict.
module bist_ora_misr #(
    parameter int                 SIG_W        = 3,
    parameter int                 NUM_PATTERNS = 7,
    parameter int                 CNT_W        = 3,
    parameter logic [SIG_W-1:0]   SEED         = 3'b000,
    parameter logic [SIG_W-1:0]   GOLDEN_SIG   = 3'b000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic             cut_sum,
    input  logic             cut_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] pattern_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

    state_t           state, state_n;
    logic [SIG_W-1:0] sig_n;
    logic [CNT_W-1:0] cnt_n, cnt_inc;
    logic             pass_n, fail_n;

    // x^3+x+1 feedback: MSB folds back into bits 0 and 1.
    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s,
                                                   input logic [1:0]       d);
        logic [SIG_W-1:0] dd;
        logic [SIG_W-1:0] n;
        logic             fb;
        dd      = '0;
        dd[1:0] = d;
        fb      = s[SIG_W-1];
        n       = '0;
        n[0]    = fb ^ dd[0];
        n[1]    = s[0] ^ fb ^ dd[1];
        for (int i = 2; i < SIG_W; i++) n[i] = s[i-1] ^ dd[i];
        return n;
    endfunction

    assign cnt_inc = pattern_cnt + CNT_W'(1);

    always_comb begin
        state_n = state;
        sig_n   = signature;
        cnt_n   = pattern_cnt;
        pass_n  = pass;
        fail_n  = fail;
        if (start) begin
            // start wins everywhere: clear and open a fresh window
            state_n = RUN;
            sig_n   = SEED;
            cnt_n   = '0;
            pass_n  = 1'b0;
            fail_n  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (in_valid) begin
                        sig_n = misr_next(signature, {cut_carry, cut_sum});
                        cnt_n = cnt_inc;
                        if (cnt_inc == CNT_W'(NUM_PATTERNS)) state_n = CHECK;
                    end
                end
                CHECK: begin
                    state_n = DONE;
                    pass_n  = (signature == GOLDEN_SIG);
                    fail_n  = (signature != GOLDEN_SIG);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            signature   <= SEED;
            pattern_cnt <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_n;
            signature   <= sig_n;
            pattern_cnt <= cnt_n;
            busy        <= (state_n == RUN) || (state_n == CHECK);
            done        <= (state_n == DONE);
            pass        <= pass_n;
            fail        <= fail_n;
        end
    end

endmodule

// File: tb/tb_bist_ora_misr.sv
// Bench for bist_ora_misr: directed window scenarios plus randomized traffic
// checked against an arithmetic model of the signature and verdict timing.
module tb_bist_ora_misr;

    localparam int NPAT = 7;
    localparam int P_IDLE = 0, P_RUN = 1, P_CHECK = 2, P_DONE = 3;

    logic       clock = 1'b0;
    logic       reset, start, in_valid, cut_sum, cut_carry;
    logic       busy, done, pass, fail;
    logic [2:0] signature, pattern_cnt;
    logic       g_busy, g_done, g_pass, g_fail;
    logic [2:0] g_signature, g_pattern_cnt;

    int checks = 0;
    int errors = 0;

    // reference model
    int m_sig, m_cnt, m_phase;
    logic m_pass, m_fail;

    bist_ora_misr dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .cut_sum(cut_sum), .cut_carry(cut_carry), .busy(busy), .done(done),
        .pass(pass), .fail(fail), .signature(signature), .pattern_cnt(pattern_cnt)
    );

    bist_ora_misr #(.GOLDEN_SIG(3'b101)) dut_g (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .cut_sum(cut_sum), .cut_carry(cut_carry), .busy(g_busy), .done(g_done),
        .pass(g_pass), .fail(g_fail), .signature(g_signature), .pattern_cnt(g_pattern_cnt)
    );

    always #5 clock = ~clock;

    // Signature as a number: shift left, reduce by x^3+x+1 on overflow, add data.
    function automatic int ref_step(input int s, input logic c, input logic su);
        int v;
        v = s * 2;
        if (v >= 8) v = (v - 8) ^ 3;
        return v ^ (int'(c) * 2 + int'(su));
    endfunction

    task automatic model_reset();
        m_sig = 0; m_cnt = 0; m_phase = P_IDLE; m_pass = 1'b0; m_fail = 1'b0;
    endtask

    // One clock with the given inputs; model follows the edge; outputs settle by return.
    task automatic tick(input logic st, input logic v, input logic su, input logic ca);
        start = st; in_valid = v; cut_sum = su; cut_carry = ca;
        @(posedge clock);
        if (st) begin
            m_sig = 0; m_cnt = 0; m_phase = P_RUN; m_pass = 1'b0; m_fail = 1'b0;
        end else if (m_phase == P_RUN && v) begin
            m_sig = ref_step(m_sig, ca, su);
            m_cnt++;
            if (m_cnt == NPAT) m_phase = P_CHECK;
        end else if (m_phase == P_CHECK) begin
            m_phase = P_DONE;
            m_pass = (m_sig == 0);
            m_fail = (m_sig != 0);
        end
        #1;
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1; in_valid = 1'b1; cut_sum = 1'b1; cut_carry = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, done, pass, fail, signature, pattern_cnt} !== 10'b0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b",
                     {busy, done, pass, fail, signature, pattern_cnt}, 10'b0);
        end
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b1;
        tick(0, 1, 1, 0);
        checks++;
        if (busy !== 1'b0 || signature !== 3'd0 || pattern_cnt !== 3'd0) begin
            errors++;
            $display("FAIL idle_ignores_valid: busy=%b sig=%0d cnt=%0d expected 0/0/0",
                     busy, signature, pattern_cnt);
        end
    endtask

    task automatic test_all_zero();
        tick(1, 0, 0, 0);
        checks++;
        if (busy !== 1'b1 || signature !== 3'd0 || pattern_cnt !== 3'd0) begin
            errors++;
            $display("FAIL t1_start: busy=%b sig=%0d cnt=%0d expected 1/0/0", busy, signature, pattern_cnt);
        end
        for (int i = 0; i < NPAT; i++) begin
            tick(0, 1, 0, 0);
            checks++;
            if (signature !== 3'd0 || pattern_cnt !== 3'(i + 1)) begin
                errors++;
                $display("FAIL t1_sample%0d: sig=%0d cnt=%0d expected 0/%0d", i, signature, pattern_cnt, i + 1);
            end
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL t1_check_state: busy=%b done=%b expected 1/0", busy, done);
        end
        tick(0, 0, 0, 0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || pattern_cnt !== 3'd7) begin
            errors++;
            $display("FAIL t1_verdict: done=%b pass=%b fail=%b busy=%b cnt=%0d expected 1/1/0/0/7",
                     done, pass, fail, busy, pattern_cnt);
        end
    endtask

    task automatic test_single_one(input int gap);
        logic [2:0] trace [NPAT];
        trace = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
        tick(1, 0, 0, 0);
        for (int i = 0; i < NPAT; i++) begin
            tick(0, 1, (i == 0), 1'b0);
            checks++;
            if (signature !== trace[i] || pattern_cnt !== 3'(i + 1)) begin
                errors++;
                $display("FAIL t2_trace%0d: sig=%0d cnt=%0d expected %0d/%0d",
                         i, signature, pattern_cnt, trace[i], i + 1);
            end
            if (i == 2) begin
                for (int g = 0; g < gap; g++) begin
                    tick(0, 0, 1'($urandom), 1'($urandom));
                    checks++;
                    if (signature !== 3'd4 || pattern_cnt !== 3'd3 || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL t3_gap%0d: sig=%0d cnt=%0d busy=%b expected 4/3/1",
                                 g, signature, pattern_cnt, busy);
                    end
                end
            end
        end
        tick(0, 0, 0, 0);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || fail !== 1'b1 || signature !== 3'd5) begin
            errors++;
            $display("FAIL t2_verdict: done=%b pass=%b fail=%b sig=%0d expected 1/0/1/5",
                     done, pass, fail, signature);
        end
        checks++;
        if (g_done !== 1'b1 || g_pass !== 1'b1 || g_fail !== 1'b0) begin
            errors++;
            $display("FAIL t6_golden101: done=%b pass=%b fail=%b expected 1/1/0", g_done, g_pass, g_fail);
        end
    endtask

    task automatic test_reset_midwindow();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 1, (i == 0), 1'b0);
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({busy, done, pass, fail, signature, pattern_cnt} !== 10'b0) begin
            errors++;
            $display("FAIL t4_async_reset: got %b expected %b",
                     {busy, done, pass, fail, signature, pattern_cnt}, 10'b0);
        end
        start = 1'b1; in_valid = 1'b1; cut_sum = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (busy !== 1'b0 || signature !== 3'd0) begin
            errors++;
            $display("FAIL t4_held_in_reset: busy=%b sig=%0d expected 0/0", busy, signature);
        end
        start = 1'b0; in_valid = 1'b0;
        reset = 1'b1;
        test_all_zero();
    endtask

    task automatic test_restart_priority();
        test_single_one(0);
        tick(0, 1, 1, 1);
        checks++;
        if (signature !== 3'd5 || pattern_cnt !== 3'd7 || done !== 1'b1) begin
            errors++;
            $display("FAIL done_ignores_valid: sig=%0d cnt=%0d done=%b expected 5/7/1",
                     signature, pattern_cnt, done);
        end
        tick(1, 1, 1, 0);
        checks++;
        if (signature !== 3'd0 || pattern_cnt !== 3'd0 || done !== 1'b0 || pass !== 1'b0 ||
            fail !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t5_restart: sig=%0d cnt=%0d done=%b pass=%b fail=%b busy=%b expected 0/0/0/0/0/1",
                     signature, pattern_cnt, done, pass, fail, busy);
        end
        // restart from mid-window discards the partial result
        tick(0, 1, 1, 1);
        tick(1, 0, 0, 0);
        checks++;
        if (signature !== 3'd0 || pattern_cnt !== 3'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_midrun: sig=%0d cnt=%0d busy=%b expected 0/0/1", signature, pattern_cnt, busy);
        end
    endtask

    task automatic test_random();
        logic st;
        for (int n = 0; n < 600; n++) begin
            if (m_phase == P_IDLE || m_phase == P_DONE) st = ($urandom_range(3) == 0);
            else st = ($urandom_range(60) == 0);
            tick(st, ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
            checks++;
            if (signature !== 3'(m_sig) || pattern_cnt !== 3'(m_cnt) ||
                busy !== (m_phase == P_RUN || m_phase == P_CHECK) || done !== (m_phase == P_DONE) ||
                pass !== m_pass || fail !== m_fail) begin
                errors++;
                $display("FAIL random%0d: sig=%0d cnt=%0d b/d/p/f=%b%b%b%b expected %0d/%0d/%b%b%b%b", n,
                         signature, pattern_cnt, busy, done, pass, fail, m_sig, m_cnt,
                         (m_phase == P_RUN || m_phase == P_CHECK), (m_phase == P_DONE), m_pass, m_fail);
            end
            checks++;
            if ((pass && fail) || (!done && (pass || fail))) begin
                errors++;
                $display("FAIL verdict_exclusive%0d: done=%b pass=%b fail=%b expected exclusive, gated by done",
                         n, done, pass, fail);
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_one(0);
        test_single_one(3);
        test_reset_midwindow();
        test_restart_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
